// File: rtl/reg_ac_bank.sv
// reg_ac_bank: a bank of CORES independent accumulator (AC) registers, each
// WIDTH bits. It sits between the shared data bus and the per-core ALUs.
//
// Each lane can be loaded from the bus (wr), loaded from its ALU (ldalu),
// incremented (inc), cleared (clr), or asked to drive the bus (ldbus).
// A broadcast (bcast) loads bus lane 0 into every lane that is not clearing.
// Per-lane priority, highest first: clr > bcast > wr > ldalu > inc > hold.
//
// Ports:
//   clk      in   system clock; all state updates on the rising edge
//   rst      in   synchronous active-high reset; overrides all controls
//   bin      in   per-lane bus data, lane i = bin[i*WIDTH +: WIDTH]
//   alu_in   in   per-lane ALU result
//   wr       in   per-lane write from bin
//   ldalu    in   per-lane load from alu_in
//   inc      in   per-lane increment (wraps, sets sticky ovf)
//   clr      in   per-lane clear (also clears ovf)
//   bcast    in   load bin lane 0 into all non-clearing lanes
//   ldbus    in   per-lane bus drive request
//   bout     out  per-lane registered bus output (pre-update AC, or 0)
//   alu_out  out  per-lane AC value, straight from the register
//   zero     out  per-lane AC == 0
//   ovf      out  per-lane sticky increment-overflow flag
module reg_ac_bank #(
  parameter int WIDTH = 16,
  parameter int CORES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CORES*WIDTH-1:0] bin,
  input  logic [CORES*WIDTH-1:0] alu_in,
  input  logic [CORES-1:0]       wr,
  input  logic [CORES-1:0]       ldalu,
  input  logic [CORES-1:0]       inc,
  input  logic [CORES-1:0]       clr,
  input  logic                   bcast,
  input  logic [CORES-1:0]       ldbus,
  output logic [CORES*WIDTH-1:0] bout,
  output logic [CORES*WIDTH-1:0] alu_out,
  output logic [CORES-1:0]       zero,
  output logic [CORES-1:0]       ovf
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ac_q   [CORES];
  logic [WIDTH-1:0] ac_d   [CORES];
  logic [WIDTH-1:0] bout_q [CORES];
  logic [WIDTH-1:0] bout_d [CORES];
  logic [CORES-1:0] ovf_q;
  logic [CORES-1:0] ovf_d;
  logic [WIDTH-1:0] bcast_val;

  assign bcast_val = bin[WIDTH-1:0];

  // Next-state selection. Each source is muxed in only when its control is
  // the winning one, so unknown data on an unselected input never reaches AC.
  always_comb begin
    for (int i = 0; i < CORES; i++) begin
      ac_d[i]  = ac_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr[i]) begin
        ac_d[i]  = '0;
        ovf_d[i] = 1'b0;
      end else if (bcast) begin
        ac_d[i]  = bcast_val;
        ovf_d[i] = 1'b0;
      end else if (wr[i]) begin
        ac_d[i]  = bin[i*WIDTH +: WIDTH];
        ovf_d[i] = 1'b0;
      end else if (ldalu[i]) begin
        ac_d[i]  = alu_in[i*WIDTH +: WIDTH];
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        ac_d[i] = ac_q[i] + ONE;
        // Wrap from all ones sets ovf; it stays set across later increments.
        if (&ac_q[i]) ovf_d[i] = 1'b1;
      end
      // Bus output captures the AC value from before this edge's update.
      bout_d[i] = ldbus[i] ? ac_q[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORES; i++) begin
        ac_q[i]   <= '0;
        bout_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < CORES; i++) begin
        ac_q[i]   <= ac_d[i];
        bout_q[i] <= bout_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < CORES; g++) begin : g_lane
    assign alu_out[g*WIDTH +: WIDTH] = ac_q[g];
    assign bout[g*WIDTH +: WIDTH]    = bout_q[g];
    assign zero[g]                   = (ac_q[g] == '0);
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_reg_ac_bank.sv
module tb_reg_ac_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: WIDTH=16, CORES=4
  logic        rst;
  logic [63:0] bin, alu_in, bout, alu_out;
  logic [3:0]  wr, ldalu, inc, clr, ldbus, zero, ovf;
  logic        bcast;

  // Small DUT: WIDTH=8, CORES=1
  logic        s_rst;
  logic [7:0]  s_bin, s_alu_in, s_bout, s_alu_out;
  logic [0:0]  s_wr, s_ldalu, s_inc, s_clr, s_ldbus, s_zero, s_ovf;
  logic        s_bcast;

  reg_ac_bank #(.WIDTH(16), .CORES(4)) dut (
    .clk(clk), .rst(rst), .bin(bin), .alu_in(alu_in), .wr(wr), .ldalu(ldalu),
    .inc(inc), .clr(clr), .bcast(bcast), .ldbus(ldbus), .bout(bout),
    .alu_out(alu_out), .zero(zero), .ovf(ovf)
  );

  reg_ac_bank #(.WIDTH(8), .CORES(1)) dut_s (
    .clk(clk), .rst(s_rst), .bin(s_bin), .alu_in(s_alu_in), .wr(s_wr),
    .ldalu(s_ldalu), .inc(s_inc), .clr(s_clr), .bcast(s_bcast), .ldbus(s_ldbus),
    .bout(s_bout), .alu_out(s_alu_out), .zero(s_zero), .ovf(s_ovf)
  );

  typedef struct {
    string       name;
    int          edge_no;
    int          dut;
    int          lane;
    logic [15:0] ac;
    logic [15:0] bo;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Expected state of one lane, due after the next rising edge.
  task automatic expect_lane(input string name, input int d, input int lane,
                             input logic [15:0] ac, input logic [15:0] bo,
                             input logic z, input logic o);
    exp_t e;
    e.name = name; e.edge_no = edge_cnt + 1; e.dut = d; e.lane = lane;
    e.ac = ac; e.bo = bo; e.z = z; e.o = o;
    sb.push_back(e);
  endtask

  task automatic idle();
    rst = 1'b0; wr = '0; ldalu = '0; inc = '0; clr = '0; ldbus = '0; bcast = 1'b0;
    s_rst = 1'b0; s_wr = '0; s_ldalu = '0; s_inc = '0; s_clr = '0; s_ldbus = '0;
    s_bcast = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: at each falling edge pop every expectation due for the last edge.
  initial begin
    exp_t e;
    logic [15:0] g_ac, g_bo;
    logic g_z, g_o;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
        e = sb.pop_front();
        n_checks++;
        if (e.edge_no < edge_cnt) begin
          n_fail++;
          $display("FAIL %s: missed check window (due edge %0d, now %0d)",
                   e.name, e.edge_no, edge_cnt);
        end else begin
          if (e.dut == 0) begin
            g_ac = alu_out[e.lane*16 +: 16];
            g_bo = bout[e.lane*16 +: 16];
            g_z  = zero[e.lane];
            g_o  = ovf[e.lane];
          end else begin
            g_ac = {8'h00, s_alu_out};
            g_bo = {8'h00, s_bout};
            g_z  = s_zero[0];
            g_o  = s_ovf[0];
          end
          if (g_ac !== e.ac || g_bo !== e.bo || g_z !== e.z || g_o !== e.o) begin
            n_fail++;
            $display("FAIL %s lane%0d: got ac=%h bout=%h zero=%b ovf=%b, need ac=%h bout=%h zero=%b ovf=%b",
                     e.name, e.lane, g_ac, g_bo, g_z, g_o, e.ac, e.bo, e.z, e.o);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bin = '0; alu_in = '0; s_bin = '0; s_alu_in = '0;
    #2;

    // 1. Reset and hold
    rst = 1'b1; s_rst = 1'b1;
    for (int l = 0; l < 4; l++) expect_lane("reset", 0, l, 16'h0, 16'h0, 1'b1, 1'b0);
    expect_lane("reset_small", 1, 0, 16'h0, 16'h0, 1'b1, 1'b0);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      expect_lane("hold_l0", 0, 0, 16'h0, 16'h0, 1'b1, 1'b0);
      expect_lane("hold_l3", 0, 3, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
    end

    // 2. Write then drive
    wr[0] = 1'b1; bin[15:0] = 16'd16;
    expect_lane("wr_l0", 0, 0, 16'd16, 16'h0, 1'b0, 1'b0);
    step(); idle();
    ldbus[0] = 1'b1;
    expect_lane("drive_l0", 0, 0, 16'd16, 16'd16, 1'b0, 1'b0);
    step(); idle();
    expect_lane("drive_drop_l0", 0, 0, 16'd16, 16'h0, 1'b0, 1'b0);
    step();

    // 3. Write then ALU load; unselected bus data is unknown
    wr[1] = 1'b1; bin[31:16] = 16'd64;
    expect_lane("wr_l1", 0, 1, 16'd64, 16'h0, 1'b0, 1'b0);
    step(); idle();
    ldalu[1] = 1'b1; alu_in[31:16] = 16'd32; bin[31:16] = 'x;
    expect_lane("ldalu_l1", 0, 1, 16'd32, 16'h0, 1'b0, 1'b0);
    step(); idle();
    wr[1] = 1'b1; ldalu[1] = 1'b1; bin[31:16] = 16'd100; alu_in[31:16] = 16'd7;
    expect_lane("wr_over_ldalu_l1", 0, 1, 16'd100, 16'h0, 1'b0, 1'b0);
    step(); idle();

    // 4. Increment wrap
    wr[2] = 1'b1; bin[47:32] = 16'hFFFE; alu_in[47:32] = 'x;
    expect_lane("wr_l2", 0, 2, 16'hFFFE, 16'h0, 1'b0, 1'b0);
    step(); idle();
    inc[2] = 1'b1;
    expect_lane("inc1_l2", 0, 2, 16'hFFFF, 16'h0, 1'b0, 1'b0);
    step();
    expect_lane("inc_wrap_l2", 0, 2, 16'h0000, 16'h0, 1'b1, 1'b1);
    step();
    expect_lane("inc_sticky_l2", 0, 2, 16'h0001, 16'h0, 1'b0, 1'b1);
    step(); idle();
    clr[2] = 1'b1;
    expect_lane("clr_l2", 0, 2, 16'h0000, 16'h0, 1'b1, 1'b0);
    step(); idle();

    // 5. Broadcast and priority
    bin = 64'h0000_1111_2222_00A5;
    bcast = 1'b1; clr[3] = 1'b1; wr[1] = 1'b1;
    expect_lane("bcast_l0", 0, 0, 16'h00A5, 16'h0, 1'b0, 1'b0);
    expect_lane("bcast_l1", 0, 1, 16'h00A5, 16'h0, 1'b0, 1'b0);
    expect_lane("bcast_l2", 0, 2, 16'h00A5, 16'h0, 1'b0, 1'b0);
    expect_lane("bcast_clr_l3", 0, 3, 16'h0000, 16'h0, 1'b1, 1'b0);
    step(); idle();
    wr[0] = 1'b1; bin[15:0] = 16'd5;
    expect_lane("wr5_l0", 0, 0, 16'd5, 16'h0, 1'b0, 1'b0);
    step(); idle();
    wr[0] = 1'b1; ldbus[0] = 1'b1; bin[15:0] = 16'd9;
    expect_lane("wr_ldbus_old_l0", 0, 0, 16'd9, 16'd5, 1'b0, 1'b0);
    step(); idle();
    ldbus = 4'b1111;
    expect_lane("multi_drive_l0", 0, 0, 16'd9, 16'd9, 1'b0, 1'b0);
    expect_lane("multi_drive_l1", 0, 1, 16'h00A5, 16'h00A5, 1'b0, 1'b0);
    expect_lane("multi_drive_l2", 0, 2, 16'h00A5, 16'h00A5, 1'b0, 1'b0);
    expect_lane("multi_drive_l3", 0, 3, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step(); idle();

    // 6. Reset mid-operation, plus the 8-bit single-lane instance
    wr[0] = 1'b1; wr[3] = 1'b1; bin = 64'hFFFF_0000_0000_1234;
    s_wr = 1'b1; s_bin = 8'hFF;
    expect_lane("wr_l0_1234", 0, 0, 16'h1234, 16'h0, 1'b0, 1'b0);
    expect_lane("wr_l3_ffff", 0, 3, 16'hFFFF, 16'h0, 1'b0, 1'b0);
    expect_lane("small_wr_ff", 1, 0, 16'h00FF, 16'h0, 1'b0, 1'b0);
    step(); idle();
    inc[3] = 1'b1; s_inc = 1'b1;
    expect_lane("wrap_l3", 0, 3, 16'h0000, 16'h0, 1'b1, 1'b1);
    expect_lane("small_wrap", 1, 0, 16'h0000, 16'h0, 1'b1, 1'b1);
    step(); idle();
    rst = 1'b1; inc = 4'b1111; ldbus = 4'b1111; s_inc = 1'b1;
    for (int l = 0; l < 4; l++) expect_lane("rst_midop", 0, l, 16'h0, 16'h0, 1'b1, 1'b0);
    expect_lane("small_inc_sticky", 1, 0, 16'h0001, 16'h0, 1'b0, 1'b1);
    step(); idle();
    expect_lane("post_rst_l0", 0, 0, 16'h0, 16'h0, 1'b1, 1'b0);
    expect_lane("post_rst_l3", 0, 3, 16'h0, 16'h0, 1'b1, 1'b0);
    s_ldbus = 1'b1;
    expect_lane("small_drive", 1, 0, 16'h0001, 16'h0001, 1'b0, 1'b1);
    step(); idle();

    // Drain: bounded wait for the monitor to consume everything.
    for (int c = 0; c < 10 && sb.size() > 0; c++) step();
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_ac_bank.md
Name: reg_ac_bank

Overview:
Parametrised multi-core accumulator bank: one AC register per core lane, each with write-from-bus, load-from-ALU, increment, clear and bus-drive controls. It generalises the single 16-bit AC to WIDTH bits and CORES lanes. It adds synchronous reset, broadcast write, a per-lane zero flag and a sticky overflow flag. It sits between the shared data bus and the per-core ALUs in the multicore datapath.

Parameters:
WIDTH, 16, data width of each AC lane
CORES, 4, number of independent AC lanes (1..16)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
bin  input  CORES*WIDTH  per-lane bus data in; lane i = bin[i*WIDTH +: WIDTH]
alu_in  input  CORES*WIDTH  per-lane ALU result in
wr  input  CORES  per-lane write: AC <= bin lane
ldalu  input  CORES  per-lane load: AC <= alu_in lane
inc  input  CORES  per-lane increment: AC <= AC+1
clr  input  CORES  per-lane clear: AC <= 0
bcast  input  1  broadcast: every lane AC <= bin lane 0
ldbus  input  CORES  per-lane bus drive request
bout  output  CORES*WIDTH  per-lane registered bus output
alu_out  output  CORES*WIDTH  per-lane AC value to ALU (direct from register)
zero  output  CORES  per-lane flag: AC == 0
ovf  output  CORES  per-lane sticky increment-overflow flag

Behaviour:
- Reset (rst=1 at rising edge): all AC=0, bout=0, ovf=0; zero=all ones. rst overrides every other input that cycle.
- Per-lane priority at each rising edge, highest first: clr > bcast > wr > ldalu > inc > hold.
- clr: AC<=0, ovf<=0.
- bcast: AC<=bin[WIDTH-1:0] in all lanes not clearing that cycle. Overrides per-lane wr/ldalu/inc. ovf<=0.
- wr: AC<=bin lane, ovf<=0.
- ldalu: AC<=alu_in lane, ovf<=0.
- inc: AC<=(AC+1) mod 2^WIDTH. If AC was all ones: AC wraps to 0 and ovf<=1. ovf stays 1 until clr/bcast/wr/ldalu/rst.
- No control asserted: AC and ovf hold.
- alu_out lane = AC register, combinational from the register. A value loaded at edge N is visible after edge N (zero-cycle read latency).
- zero lane = (AC == 0), combinational from the register.
- bout, per lane, registered:
  - ldbus=1 at edge N: bout <= AC value before edge N's update. A simultaneous wr and ldbus drives the old value out.
  - ldbus=0: bout <= 0.
  - Effective latency: write at edge N, ldbus at edge N+1, so bout shows the new value after edge N+1.
- Lanes are fully independent, except bcast, which reads lane 0 of bin.
- bin/alu_in contents are don't-care when no load selects them. X on an unselected input must not propagate into AC.
- Reset mid-operation: pending inc/wr/ldbus that cycle are discarded. No state survives.
- Concurrency: there is no bus-contention arbitration inside the block. Multiple ldbus bits may be high. The external bus mux owns exclusivity.

Test Plan:
1. Reset and hold: rst=1 for one edge -> all bout=0, alu_out=0, zero=4'b1111, ovf=0. Release with no controls for 3 cycles -> unchanged.
2. Write then drive: lane0 wr, bin lane0=16 at edge 1; ldbus[0] at edge 2 -> alu_out lane0=16 after edge 1, bout lane0=16 after edge 2, bout lane0=0 after edge 3 once ldbus drops.
3. Write then ALU load: lane1 wr=64, then ldalu with alu_in=32 -> alu_out lane1=64 then 32. Simultaneous wr(100)+ldalu(7) -> 100. zero[1]=0 throughout.
4. Increment wrap: lane2 wr=16'hFFFE, inc x2 -> 16'hFFFF, then 0 with ovf[2]=1 and zero[2]=1. A further inc -> 1, ovf[2] still 1. clr -> 0, ovf[2]=0.
5. Broadcast and priority: bin lane0=16'h00A5, bcast=1, clr[3]=1, wr[1]=1 -> lanes 0-2 = 16'h00A5, lane3=0. Same-edge wr+ldbus on lane0 with old AC=5, new 9 -> bout lane0=5.
6. Reset mid-op: lane0 = 16'h1234 with inc and ldbus asserted, rst=1 same edge -> AC=0, bout=0, ovf=0. Also run CORES=1, WIDTH=8: inc from 8'hFF -> 0 with ovf=1.
